// File: rtl/data_memory_responder_if.sv
// Core-side data-memory handshake and console byte stream for data_memory_responder.
// The tristate data_bus stays a plain module port so the bus is resolved at a single boundary.
interface data_memory_responder_if;
    logic [31:0] data_address;
    logic        data_rw;
    logic        data_cs;
    logic [1:0]  data_mode;
    logic        con_valid;
    logic [7:0]  con_data;
    logic        con_ready;

    // master: the core plus the console sink; slave: the responder
    modport master (
        output data_address, data_rw, data_cs, data_mode, con_ready,
        input  con_valid, con_data
    );
    modport slave (
        input  data_address, data_rw, data_cs, data_mode, con_ready,
        output con_valid, con_data
    );
endinterface

// File: rtl/data_memory_responder.sv
// Single-cycle data RAM (byte/half/word, big-endian) with MMIO console FIFO, status and cycle counter.
// Optional: define DMEM_CYCLE_COUNTER_EN to build the free-running CYCLE register.
module data_memory_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF0000
) (
    input  logic                    clk,
    input  logic                    rst,
    inout  wire  [31:0]             data_bus,
    data_memory_responder_if.slave  bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] OFF_CON    = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;

    logic [31:0] addr, wdata, rdata, status, cycle_val;
    logic [1:0]  off;
    logic        is_mmio, misalign, rd_en, wr_en;

    assign addr    = bus.data_address;
    assign wdata   = data_bus;
    assign off     = addr[3:2];
    assign is_mmio = addr[31:16] == MMIO_BASE[31:16];
    assign rd_en   = bus.data_cs && bus.data_rw;
    assign wr_en   = bus.data_cs && !bus.data_rw;

    // MMIO is always word-wide, so alignment only matters for RAM
    always_comb begin
        misalign = 1'b0;
        case (bus.data_mode)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr[0];
            default: misalign = addr[1:0] != 2'b00;
        endcase
        if (is_mmio) misalign = 1'b0;
    end

    // ---------------- RAM ----------------
    logic [31:0]   mem [MEM_WORDS];
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram_word, merged;

    assign ram_idx  = addr[AW+1:2];
    assign ram_word = mem[ram_idx];

    always_comb begin
        merged = ram_word;
        case (bus.data_mode)
            2'b00: begin
                case (addr[1:0])
                    2'd0: merged[31:24] = wdata[7:0];
                    2'd1: merged[23:16] = wdata[7:0];
                    2'd2: merged[15:8]  = wdata[7:0];
                    default: merged[7:0] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (addr[1]) merged[15:0]  = wdata[15:0];
                else         merged[31:16] = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en && !is_mmio && !misalign)
            mem[ram_idx] <= merged;
    end

    // ---------------- console FIFO and sticky flags ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] rd_ptr, wr_ptr;
    logic [FW:0]   count;
    logic [8:0]    cnt_ext;
    logic          empty, full, push_req, push, pop, stat_wr;
    logic          overflow_q, misalign_q, ovf_set, ovf_clr, mis_set, mis_clr;

    assign empty    = count == '0;
    assign full     = count == (FW+1)'(FIFO_DEPTH);
    assign pop      = !empty && bus.con_ready;
    assign push_req = wr_en && is_mmio && off == OFF_CON;
    assign push     = push_req && (!full || pop);
    assign stat_wr  = wr_en && is_mmio && off == OFF_STATUS;
    assign ovf_set  = push_req && !push;
    assign ovf_clr  = stat_wr && wdata[2];
    assign mis_set  = bus.data_cs && misalign;
    assign mis_clr  = stat_wr && wdata[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // a set in the same cycle as its clear wins
            overflow_q <= ovf_set | (overflow_q & ~ovf_clr);
            misalign_q <= mis_set | (misalign_q & ~mis_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wdata[7:0];
    end

    assign bus.con_valid = !empty;
    assign bus.con_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    assign cnt_ext = 9'(count);
    assign status  = {16'h0, cnt_ext[7:0], 4'h0, misalign_q, overflow_q, full, empty};

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_q + 32'd1;
    end
    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // ---------------- read path ----------------
    always_comb begin
        rdata = '0;
        if (is_mmio) begin
            case (off)
                OFF_STATUS: rdata = status;
                OFF_CYCLE:  rdata = cycle_val;
                default:    rdata = '0;
            endcase
        end else if (!misalign) begin
            case (bus.data_mode)
                2'b00: begin
                    case (addr[1:0])
                        2'd0: rdata[7:0] = ram_word[31:24];
                        2'd1: rdata[7:0] = ram_word[23:16];
                        2'd2: rdata[7:0] = ram_word[15:8];
                        default: rdata[7:0] = ram_word[7:0];
                    endcase
                end
                2'b01:   rdata[15:0] = addr[1] ? ram_word[15:0] : ram_word[31:16];
                default: rdata = ram_word;
            endcase
        end
    end

    assign data_bus = (rd_en && !rst) ? rdata : 'z;

    logic unused_bits;
    assign unused_bits = ^{addr, cnt_ext[8]};
endmodule
